// File: rtl/burst_requester_if.sv
// Signal bundle shared by the client, the burst requester and the burst engine.
// The master view belongs to the requester. The slave view belongs to whatever drives
// the client and engine sides.
interface burst_requester_if;
    logic        CmdValid;
    logic        CmdReady;
    logic [19:0] CmdAddress;
    logic [3:0]  CmdLength;
    logic        WrValid;
    logic        WrReady;
    logic [15:0] WrData;
    logic        BurstCE;
    logic [19:0] BurstAddress;
    logic [15:0] BurstData;
    logic        BurstYield;
    logic        BurstDone;
    logic        Busy;
    logic        Overrun;

    modport master (
        input  CmdValid, CmdAddress, CmdLength, WrValid, WrData, BurstYield, BurstDone,
        output CmdReady, WrReady, BurstCE, BurstAddress, BurstData, Busy, Overrun
    );

    modport slave (
        output CmdValid, CmdAddress, CmdLength, WrValid, WrData, BurstYield, BurstDone,
        input  CmdReady, WrReady, BurstCE, BurstAddress, BurstData, Busy, Overrun
    );
endinterface

// File: rtl/burst_requester.sv
// Burst requester.
// The block queues client commands and write data. It launches a burst toward the burst
// engine once the data for the head command has been fully buffered.
//
// state  | meaning
// IDLE   | waiting for a queued command whose data is fully buffered
// LAUNCH | command popped, address/length latched, BurstCE rises next
// ACTIVE | BurstCE high, engine consumes words with BurstYield
// FLUSH  | engine quit early; drop the unconsumed words of this burst
// GAP    | one forced low cycle before returning to IDLE
module burst_requester #(
    parameter int CMD_DEPTH  = 4,
    parameter int DATA_DEPTH = 16
) (
    input  logic              CLK,
    input  logic              nReset,
    burst_requester_if.master bus
);
    localparam int CAW = $clog2(CMD_DEPTH);
    localparam int DAW = $clog2(DATA_DEPTH);
    localparam logic [CAW:0] CMD_FULL  = (CAW+1)'(CMD_DEPTH);
    localparam logic [DAW:0] DATA_FULL = (DAW+1)'(DATA_DEPTH);

    typedef enum logic [2:0] {IDLE, LAUNCH, ACTIVE, FLUSH, GAP} state_t;

    logic [19:0]    cmdAddrMem [CMD_DEPTH];
    logic [3:0]     cmdLenMem  [CMD_DEPTH];
    logic [CAW-1:0] cmdWrPtr, cmdRdPtr;
    logic [CAW:0]   cmdCount;

    logic [15:0]    dataMem [DATA_DEPTH];
    logic [DAW-1:0] dataWrPtr, dataRdPtr;
    logic [DAW:0]   dataCount;

    state_t      state;
    logic [3:0]  burstLen, wordCnt, wordNext;
    logic        burstCE;
    logic [19:0] burstAddr;
    logic        overrun;

    logic       cmdFull, dataFull, lenBad, launchOk, yieldOk;
    logic       cmdPush, cmdPop, dataPush, dataPop;
    logic [3:0] lenIn, headLen;

    // Handshake decode, the launch condition and the FIFO push/pop strobes
    always_comb begin
        lenBad   = (bus.CmdLength == 4'd0) || (bus.CmdLength > 4'd8);
        lenIn    = lenBad ? 4'd8 : bus.CmdLength;
        cmdFull  = (cmdCount == CMD_FULL);
        dataFull = (dataCount == DATA_FULL);
        headLen  = cmdLenMem[cmdRdPtr];
        cmdPush  = bus.CmdValid && !cmdFull;
        launchOk = (state == IDLE) && (cmdCount != '0) && (32'(dataCount) >= 32'(headLen));
        cmdPop   = launchOk;
        yieldOk  = (state == ACTIVE) && bus.BurstYield && (wordCnt != burstLen);
        dataPop  = yieldOk || (state == FLUSH);
        // A full data FIFO still takes a word when a pop frees a slot in the same cycle
        dataPush = bus.WrValid && (!dataFull || dataPop);
        wordNext = yieldOk ? wordCnt + 4'd1 : wordCnt;
    end

    assign bus.CmdReady     = !cmdFull;
    assign bus.WrReady      = !dataFull || dataPop;
    assign bus.BurstData    = (dataCount == '0) ? 16'h0000 : dataMem[dataRdPtr];
    assign bus.BurstCE      = burstCE;
    assign bus.BurstAddress = burstAddr;
    assign bus.Busy         = (state != IDLE);
    assign bus.Overrun      = overrun;

    // Command FIFO storage; contents are don't-care while the entry is not counted
    always_ff @(posedge CLK) begin
        if (cmdPush) begin
            cmdAddrMem[cmdWrPtr] <= bus.CmdAddress;
            cmdLenMem[cmdWrPtr]  <= lenIn;
        end
    end

    // Command FIFO pointers and occupancy
    always_ff @(posedge CLK) begin
        if (!nReset) begin
            cmdWrPtr <= '0;
            cmdRdPtr <= '0;
            cmdCount <= '0;
        end else begin
            if (cmdPush) cmdWrPtr <= cmdWrPtr + 1'b1;
            if (cmdPop)  cmdRdPtr <= cmdRdPtr + 1'b1;
            if (cmdPush && !cmdPop)      cmdCount <= cmdCount + 1'b1;
            else if (!cmdPush && cmdPop) cmdCount <= cmdCount - 1'b1;
        end
    end

    // Data FIFO storage
    always_ff @(posedge CLK) begin
        if (dataPush) dataMem[dataWrPtr] <= bus.WrData;
    end

    // Data FIFO pointers and occupancy
    always_ff @(posedge CLK) begin
        if (!nReset) begin
            dataWrPtr <= '0;
            dataRdPtr <= '0;
            dataCount <= '0;
        end else begin
            if (dataPush) dataWrPtr <= dataWrPtr + 1'b1;
            if (dataPop)  dataRdPtr <= dataRdPtr + 1'b1;
            if (dataPush && !dataPop)      dataCount <= dataCount + 1'b1;
            else if (!dataPush && dataPop) dataCount <= dataCount - 1'b1;
        end
    end

    // Burst sequencing FSM with registered BurstCE/BurstAddress and the sticky Overrun flag
    always_ff @(posedge CLK) begin
        if (!nReset) begin
            state     <= IDLE;
            burstCE   <= 1'b0;
            burstAddr <= '0;
            burstLen  <= '0;
            wordCnt   <= '0;
            overrun   <= 1'b0;
        end else begin
            if (cmdPush && lenBad) overrun <= 1'b1;
            if ((state != ACTIVE) && (bus.BurstYield || bus.BurstDone)) overrun <= 1'b1;

            case (state)
                IDLE: begin
                    if (launchOk) begin
                        state     <= LAUNCH;
                        burstAddr <= cmdAddrMem[cmdRdPtr];
                        burstLen  <= headLen;
                        wordCnt   <= '0;
                    end
                end
                LAUNCH: begin
                    state   <= ACTIVE;
                    burstCE <= 1'b1;
                end
                ACTIVE: begin
                    if (bus.BurstYield && !yieldOk) overrun <= 1'b1;
                    wordCnt <= wordNext;
                    // A yield in the same cycle as done counts first
                    if (bus.BurstDone) begin
                        burstCE <= 1'b0;
                        state   <= (wordNext < burstLen) ? FLUSH : GAP;
                    end
                end
                FLUSH: begin
                    wordCnt <= wordCnt + 4'd1;
                    if (wordCnt + 4'd1 == burstLen) state <= GAP;
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    burstCE <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_burst_requester.sv
// Directed bench for burst_requester with a data/address scoreboard.
module tb_burst_requester;
    logic CLK = 1'b0;
    logic nReset;

    burst_requester_if bus();

    burst_requester #(.CMD_DEPTH(4), .DATA_DEPTH(16)) dut (
        .CLK    (CLK),
        .nReset (nReset),
        .bus    (bus.master)
    );

    always #5 CLK = ~CLK;

    int          total = 0;
    int          bad   = 0;
    logic [15:0] dataQ[$];
    logic [19:0] addrQ[$];
    logic [19:0] curAddr;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] popData();
        if (dataQ.size() == 0) return 16'hxxxx;
        return dataQ.pop_front();
    endfunction

    function automatic logic [19:0] popAddr();
        if (addrQ.size() == 0) return 20'hxxxxx;
        return addrQ.pop_front();
    endfunction

    task automatic sendCmd(input logic [19:0] a, input logic [3:0] l);
        bus.CmdValid   = 1'b1;
        bus.CmdAddress = a;
        bus.CmdLength  = l;
        addrQ.push_back(a);
        tick();
        bus.CmdValid = 1'b0;
    endtask

    task automatic sendWord(input logic [15:0] d);
        bus.WrValid = 1'b1;
        bus.WrData  = d;
        dataQ.push_back(d);
        tick();
        bus.WrValid = 1'b0;
    endtask

    task automatic waitCE(input string tag);
        int n = 0;
        while (bus.BurstCE !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        check({tag, "_ce_rise"}, bus.BurstCE, 1);
        curAddr = popAddr();
        check({tag, "_addr"}, bus.BurstAddress, curAddr);
    endtask

    task automatic waitIdle(input string tag);
        int n = 0;
        while (bus.Busy !== 1'b0 && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_idle"}, bus.Busy, 0);
    endtask

    task automatic burst(input string tag, input int n, input bit withDone);
        for (int k = 0; k < n; k++) begin
            check({tag, "_ce_hi"}, bus.BurstCE, 1);
            check({tag, "_addr_hold"}, bus.BurstAddress, curAddr);
            check({tag, "_data"}, bus.BurstData, popData());
            bus.BurstYield = 1'b1;
            bus.BurstDone  = withDone && (k == n - 1);
            tick();
        end
        bus.BurstYield = 1'b0;
        bus.BurstDone  = 1'b0;
    endtask

    task automatic doReset(input string tag);
        bus.CmdValid   = 1'b0;
        bus.WrValid    = 1'b0;
        bus.BurstYield = 1'b0;
        bus.BurstDone  = 1'b0;
        nReset = 1'b0;
        tick();
        check({tag, "_ce"},       bus.BurstCE, 0);
        check({tag, "_addr"},     bus.BurstAddress, 0);
        check({tag, "_overrun"},  bus.Overrun, 0);
        check({tag, "_busy"},     bus.Busy, 0);
        check({tag, "_cmdready"}, bus.CmdReady, 1);
        check({tag, "_wrready"},  bus.WrReady, 1);
        check({tag, "_data"},     bus.BurstData, 0);
        nReset = 1'b1;
        dataQ.delete();
        addrQ.delete();
    endtask

    initial begin
        nReset         = 1'b0;
        bus.CmdValid   = 1'b0;
        bus.CmdAddress = '0;
        bus.CmdLength  = '0;
        bus.WrValid    = 1'b0;
        bus.WrData     = '0;
        bus.BurstYield = 1'b0;
        bus.BurstDone  = 1'b0;
        doReset("rst0");
        tick();

        // Basic burst; the command and the first word arrive in the same cycle
        bus.CmdValid   = 1'b1;
        bus.CmdAddress = 20'h00100;
        bus.CmdLength  = 4'd4;
        addrQ.push_back(20'h00100);
        for (int i = 0; i < 4; i++) begin
            bus.WrValid = 1'b1;
            bus.WrData  = 16'h00A0 + 16'(i);
            dataQ.push_back(16'h00A0 + 16'(i));
            tick();
            bus.CmdValid = 1'b0;
        end
        bus.WrValid = 1'b0;
        check("t1_idle_busy", bus.Busy, 0);
        tick();
        check("t1_launch_busy", bus.Busy, 1);
        check("t1_launch_ce", bus.BurstCE, 0);
        tick();
        waitCE("t1");
        burst("t1", 4, 1'b1);
        check("t1_ce_drop", bus.BurstCE, 0);
        check("t1_gap_busy", bus.Busy, 1);
        tick();
        check("t1_back_idle", bus.Busy, 0);
        check("t1_empty_data", bus.BurstData, 0);

        // A burst must wait until all of its words are buffered
        sendCmd(20'h00200, 4'd4);
        for (int i = 0; i < 3; i++) sendWord(16'h00B0 + 16'(i));
        repeat (4) begin
            tick();
            check("t2_hold_ce", bus.BurstCE, 0);
            check("t2_hold_busy", bus.Busy, 0);
        end
        sendWord(16'h00B3);
        check("t2_w4_busy", bus.Busy, 0);
        tick();
        check("t2_launch_busy", bus.Busy, 1);
        check("t2_launch_ce", bus.BurstCE, 0);
        tick();
        waitCE("t2");
        burst("t2", 4, 1'b1);
        waitIdle("t2");

        // Early done leads to a flush, and the next burst starts on its own first word
        sendCmd(20'h00300, 4'd8);
        sendCmd(20'h00400, 4'd2);
        for (int i = 0; i < 8; i++) sendWord(16'h00C0 + 16'(i));
        sendWord(16'h00D0);
        sendWord(16'h00D1);
        waitCE("t3a");
        burst("t3a", 5, 1'b1);
        check("t3_ce_drop", bus.BurstCE, 0);
        check("t3_flush_busy", bus.Busy, 1);
        repeat (3) void'(popData());
        waitCE("t3b");
        check("t3_overrun", bus.Overrun, 0);
        burst("t3b", 2, 1'b1);
        waitIdle("t3");

        // Command FIFO fills up; the fifth command goes in after the first launch pop
        for (int i = 1; i <= 4; i++) sendCmd(20'h00500 + 20'(i), 4'd1);
        check("t4_full", bus.CmdReady, 0);
        bus.CmdValid   = 1'b1;
        bus.CmdAddress = 20'h00505;
        bus.CmdLength  = 4'd1;
        addrQ.push_back(20'h00505);
        tick();
        check("t4_stall", bus.CmdReady, 0);
        bus.WrValid = 1'b1;
        bus.WrData  = 16'h00E0;
        dataQ.push_back(16'h00E0);
        tick();
        bus.WrValid = 1'b0;
        check("t4_pre_pop", bus.CmdReady, 0);
        tick();
        check("t4_after_pop", bus.CmdReady, 1);
        check("t4_launch_busy", bus.Busy, 1);
        tick();
        bus.CmdValid = 1'b0;
        check("t4_fifth_in", bus.CmdReady, 0);
        for (int i = 1; i <= 4; i++) sendWord(16'h00E0 + 16'(i));
        for (int i = 0; i < 5; i++) begin
            waitCE("t4");
            burst("t4", 1, 1'b1);
        end
        waitIdle("t4");

        // Yield and done outside ACTIVE set Overrun and do not pop data
        check("t5_overrun_clear", bus.Overrun, 0);
        sendWord(16'h0F00);
        bus.BurstDone = 1'b1;
        tick();
        bus.BurstDone = 1'b0;
        check("t5_done_idle_ovr", bus.Overrun, 1);
        check("t5_done_no_pop", bus.BurstData, dataQ[0]);
        bus.BurstYield = 1'b1;
        tick();
        bus.BurstYield = 1'b0;
        check("t5_yield_no_pop", bus.BurstData, dataQ[0]);
        repeat (3) tick();
        check("t5_sticky", bus.Overrun, 1);
        doReset("r1");

        // A yield past the burst length sets Overrun and does not pop
        sendCmd(20'h00600, 4'd2);
        for (int i = 0; i < 3; i++) sendWord(16'h00F0 + 16'(i));
        waitCE("t6");
        burst("t6", 2, 1'b0);
        check("t6_ce_still", bus.BurstCE, 1);
        bus.BurstYield = 1'b1;
        tick();
        bus.BurstYield = 1'b0;
        check("t6_overrun", bus.Overrun, 1);
        check("t6_no_pop", bus.BurstData, dataQ[0]);
        bus.BurstDone = 1'b1;
        tick();
        bus.BurstDone = 1'b0;
        check("t6_ce_drop", bus.BurstCE, 0);
        waitIdle("t6");
        check("t6_sticky", bus.Overrun, 1);
        doReset("r2");

        // A length-0 command runs as 8 words; then reset mid-burst with 6 words and a command still queued
        sendCmd(20'h00700, 4'd0);
        check("t7_len0_ovr", bus.Overrun, 1);
        for (int i = 0; i < 8; i++) sendWord(16'h1000 + 16'(i));
        waitCE("t7");
        burst("t7", 2, 1'b0);
        sendCmd(20'h00800, 4'd1);
        doReset("r_mid");
        repeat (6) begin
            tick();
            check("t7_post_ce", bus.BurstCE, 0);
            check("t7_post_busy", bus.Busy, 0);
        end

        // A length of 9 is clamped to an 8-word burst with no flush
        sendCmd(20'h00900, 4'd9);
        check("t8_len9_ovr", bus.Overrun, 1);
        for (int i = 0; i < 8; i++) sendWord(16'h2000 + 16'(i));
        waitCE("t8");
        burst("t8", 8, 1'b1);
        check("t8_ce_drop", bus.BurstCE, 0);
        tick();
        check("t8_idle", bus.Busy, 0);
        check("t8_empty", bus.BurstData, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
